// File: rtl/sync_fifo.sv
// sync_fifo: parametrised single-clock FIFO with occupancy count,
// programmable almost-full/almost-empty flags and overflow/underflow pulses.
// Pointers carry one extra wrap bit so all DEPTH entries are usable.
// Optional first-word-fall-through output: define SYNC_FIFO_FWFT_EN.
// Without it, reads are registered (dout updates one edge after the read).
module sync_fifo #(
    parameter int DEPTH    = 4,
    parameter int WIDTH    = 69,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wen,
    input  logic [WIDTH-1:0]           din,
    input  logic                       ren,
    output logic [WIDTH-1:0]           dout,
    output logic                       dout_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] AF_THR  = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_THR  = PW'(AE_LEVEL);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          rd_acc, wr_acc;
    logic [AW-1:0] wr_idx, rd_idx;

    // Status derived purely from the registered pointers.
    always_comb begin
        wr_idx       = wr_ptr_q[AW-1:0];
        rd_idx       = rd_ptr_q[AW-1:0];
        empty        = (wr_ptr_q == rd_ptr_q);
        full         = (wr_idx == rd_idx) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        count        = wr_ptr_q - rd_ptr_q;
        almost_full  = (count >= AF_THR);
        almost_empty = (count <= AE_THR);
    end

    // Accept logic, pointer advance and refused-request pulses.
    // A write while full is still accepted when a read frees a slot the same edge.
    always_comb begin
        rd_acc      = ren & ~empty;
        wr_acc      = wen & (~full | rd_acc);
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
        overflow_d  = wen & ~wr_acc;
        underflow_d = ren & empty;
    end

    // Pointer and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array; deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_idx] <= din;
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;

`ifdef SYNC_FIFO_FWFT_EN

    // Head word is presented combinationally; ren pops it.
    always_comb begin
        dout       = mem_q[rd_idx];
        dout_valid = ~empty;
    end

`else

    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;

    // Registered read: load on an accepted read, otherwise hold.
    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = rd_acc;
        if (rd_acc) dout_d = mem_q[rd_idx];
    end

    // Read data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo in its default (registered-read) build,
// DEPTH=4, WIDTH=69, AF_LEVEL=3, AE_LEVEL=1.
module tb_sync_fifo;

    localparam int W = 69;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         wen = 1'b0;
    logic [W-1:0] din = '0;
    logic         ren = 1'b0;
    logic [W-1:0] dout;
    logic         dout_valid, full, empty, almost_full, almost_empty;
    logic [2:0]   count;
    logic         overflow, underflow;

    int total = 0;
    int bad   = 0;

    sync_fifo dut (
        .clk(clk), .rst_n(rst_n), .wen(wen), .din(din), .ren(ren),
        .dout(dout), .dout_valid(dout_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         wen;
        logic [W-1:0] din;
        logic         ren;
        logic [W-1:0] dout;
        logic         dv;
        logic [2:0]   cnt;
        logic         full;
        logic         empty;
        logic         af;
        logic         ae;
        logic         ovf;
        logic         unf;
    } vec_t;

    vec_t vecs[$];

    localparam logic [W-1:0] WIDE = 69'h1_0123_4567_89AB_CDEF;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive at the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic w, input logic [W-1:0] d, input logic r);
        @(negedge clk);
        wen = w;
        din = d;
        ren = r;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic w, input logic [W-1:0] d, input logic r,
                       input logic [W-1:0] o, input logic dv, input logic [2:0] c,
                       input logic f, input logic e, input logic af, input logic ae,
                       input logic ov, input logic un);
        vec_t v;
        v.wen = w; v.din = d; v.ren = r; v.dout = o; v.dv = dv; v.cnt = c;
        v.full = f; v.empty = e; v.af = af; v.ae = ae; v.ovf = ov; v.unf = un;
        vecs.push_back(v);
    endtask

    initial begin
        //   wen din      ren  dout     dv cnt f e af ae ov un
        add(0, 69'h0,   0, 69'h0,   0, 0, 0, 1, 0, 1, 0, 0); // idle after reset
        add(1, 69'h1,   0, 69'h0,   0, 1, 0, 0, 0, 1, 0, 0);
        add(1, 69'h2,   0, 69'h0,   0, 2, 0, 0, 0, 0, 0, 0);
        add(1, 69'h3,   0, 69'h0,   0, 3, 0, 0, 1, 0, 0, 0);
        add(1, 69'h4,   0, 69'h0,   0, 4, 1, 0, 1, 0, 0, 0);
        add(1, 69'h5,   0, 69'h0,   0, 4, 1, 0, 1, 0, 1, 0); // refused write
        add(0, 69'h0,   1, 69'h1,   1, 3, 0, 0, 1, 0, 0, 0);
        add(0, 69'h0,   1, 69'h2,   1, 2, 0, 0, 0, 0, 0, 0);
        add(0, 69'h0,   1, 69'h3,   1, 1, 0, 0, 0, 1, 0, 0);
        add(0, 69'h0,   1, 69'h4,   1, 0, 0, 1, 0, 1, 0, 0);
        add(0, 69'h0,   1, 69'h4,   0, 0, 0, 1, 0, 1, 0, 1); // refused read
        add(0, 69'h0,   0, 69'h4,   0, 0, 0, 1, 0, 1, 0, 0);
        add(1, 69'h11,  0, 69'h4,   0, 1, 0, 0, 0, 1, 0, 0);
        add(1, WIDE,    0, 69'h4,   0, 2, 0, 0, 0, 0, 0, 0);
        add(1, 69'h13,  0, 69'h4,   0, 3, 0, 0, 1, 0, 0, 0);
        add(1, 69'h14,  0, 69'h4,   0, 4, 1, 0, 1, 0, 0, 0);
        add(1, 69'hA,   1, 69'h11,  1, 4, 1, 0, 1, 0, 0, 0); // wen+ren while full
        add(0, 69'h0,   1, WIDE,    1, 3, 0, 0, 1, 0, 0, 0);
        add(0, 69'h0,   1, 69'h13,  1, 2, 0, 0, 0, 0, 0, 0);
        add(0, 69'h0,   1, 69'h14,  1, 1, 0, 0, 0, 1, 0, 0);
        add(0, 69'h0,   1, 69'hA,   1, 0, 0, 1, 0, 1, 0, 0);
        add(1, 69'hB,   1, 69'hA,   0, 1, 0, 0, 0, 1, 0, 1); // wen+ren while empty
        add(0, 69'h0,   1, 69'hB,   1, 0, 0, 1, 0, 1, 0, 0);

        #12;
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            string t;
            step(vecs[i].wen, vecs[i].din, vecs[i].ren);
            t = $sformatf("v%0d", i);
            chk({t, ".dout"},  dout,         vecs[i].dout);
            chk({t, ".dv"},    W'(dout_valid),   W'(vecs[i].dv));
            chk({t, ".count"}, W'(count),        W'(vecs[i].cnt));
            chk({t, ".full"},  W'(full),         W'(vecs[i].full));
            chk({t, ".empty"}, W'(empty),        W'(vecs[i].empty));
            chk({t, ".af"},    W'(almost_full),  W'(vecs[i].af));
            chk({t, ".ae"},    W'(almost_empty), W'(vecs[i].ae));
            chk({t, ".ovf"},   W'(overflow),     W'(vecs[i].ovf));
            chk({t, ".unf"},   W'(underflow),    W'(vecs[i].unf));
        end

        // Wrap-around: 3 writes then 3 reads, three rounds, pointers cross the wrap.
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 3; k++) begin
                step(1'b1, W'(32'h100 + r * 3 + k), 1'b0);
                chk($sformatf("wrap%0d.wcount%0d", r, k), W'(count), W'(k + 1));
                chk($sformatf("wrap%0d.wfull%0d", r, k), W'(full), W'(0));
            end
            for (int k = 0; k < 3; k++) begin
                step(1'b0, '0, 1'b1);
                chk($sformatf("wrap%0d.dout%0d", r, k), dout, W'(32'h100 + r * 3 + k));
                chk($sformatf("wrap%0d.rcount%0d", r, k), W'(count), W'(2 - k));
                chk($sformatf("wrap%0d.empty%0d", r, k), W'(empty), W'(k == 2));
            end
        end

        // Mid-operation asynchronous reset with count=2 and dout non-zero.
        step(1'b1, 69'h21, 1'b0);
        step(1'b1, 69'h22, 1'b0);
        step(1'b1, 69'h23, 1'b1);
        chk("pre_rst.count", W'(count), W'(2));
        chk("pre_rst.dout",  dout, 69'h21);
        @(negedge clk);
        wen = 1'b0;
        ren = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst.count", W'(count),        W'(0));
        chk("rst.empty", W'(empty),        W'(1));
        chk("rst.ae",    W'(almost_empty), W'(1));
        chk("rst.full",  W'(full),         W'(0));
        chk("rst.af",    W'(almost_full),  W'(0));
        chk("rst.dout",  dout,             69'h0);
        chk("rst.dv",    W'(dout_valid),   W'(0));
        chk("rst.ovf",   W'(overflow),     W'(0));
        chk("rst.unf",   W'(underflow),    W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 69'h5, 1'b0);
        chk("post_rst.count", W'(count), W'(1));
        step(1'b0, '0, 1'b1);
        chk("post_rst.dout", dout, 69'h5);
        chk("post_rst.dv",   W'(dout_valid), W'(1));
        chk("post_rst.empty", W'(empty), W'(1));
        step(1'b0, '0, 1'b0);
        chk("post_rst.dv_drop", W'(dout_valid), W'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Parametrised single-clock FIFO, the successor to the original 4-deep queue. It adds an extra-bit pointer scheme so all DEPTH entries are usable, and accepts a read and a write together when full. It also provides an occupancy count, programmable almost-full/almost-empty flags, overflow/underflow pulses and an optional first-word-fall-through output. It buffers wide datapath words between producer and consumer stages in the same clock domain.

## Interface
- DEPTH, 4, number of entries; power of two, ≥2
- WIDTH, 69, data word width in bits
- AF_LEVEL, DEPTH-1, almost_full asserts when count ≥ AF_LEVEL; range 1..DEPTH
- AE_LEVEL, 1, almost_empty asserts when count ≤ AE_LEVEL; range 0..DEPTH-1
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wen  in  1  write request
- din  in  WIDTH  write data
- ren  in  1  read request
- dout  out  WIDTH  read data
- dout_valid  out  1  dout holds valid data (meaning depends on mode, see Configuration)
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  out  1  one-cycle pulse: write refused
- underflow  out  1  one-cycle pulse: read refused

## Operation
- Storage: DEPTH × WIDTH array; wr_ptr/rd_ptr are $clog2(DEPTH)+1 bits and wrap modulo 2·DEPTH; the low bits index the array.
- empty = pointers equal. full = low bits equal and MSBs differ. count = wr_ptr − rd_ptr (modulo, full width).
- Read accepted: rd_acc = ren & !empty.
- Write accepted: wr_acc = wen & (!full | rd_acc). Simultaneous read and write while full are both accepted; count is unchanged.
- While empty, wen & ren accepts the write only. The read is refused and underflow pulses.
- Refused write (wen & !wr_acc): the array and pointers are unchanged; overflow = 1 next cycle.
- Refused read (ren & empty): underflow = 1 next cycle. dout holds its value.
- The array is not reset. Pointers, count and flags are reset.
- Reset (rst_n low, any time, including mid-burst): pointers = 0, count = 0, empty = 1, almost_empty = 1, full = 0, almost_full = 0 (given AF_LEVEL ≥ 1), overflow = 0, underflow = 0, dout = 0, dout_valid = 0. Pending contents are discarded.

## Timing
- Write latency: a word written at edge N appears in count and flags after edge N.
- Flags and count are combinational from the registered pointers, so they are glitch-free relative to clk.
- Standard mode: on rd_acc at edge N, dout = mem[rd_ptr] and dout_valid = 1 after edge N. dout_valid is 0 after any edge without rd_acc; dout holds its last value.
- Minimum write-to-data latency (empty FIFO, standard mode): write at edge N, ren at edge N+1, data at edge N+1 output.
- overflow/underflow are registered; each is high for exactly one cycle per refused request.

## Configuration
- Macro SYNC_FIFO_FWFT_EN.
- Undefined (standard mode): registered read as described in Timing.
- Defined (first-word-fall-through):
  - dout = mem[rd_ptr low bits] combinationally; dout_valid = !empty.
  - ren acts as an acknowledge/pop of the current head word.
  - A word written into an empty FIFO at edge N is on dout with dout_valid = 1 after edge N.
  - Reset value: dout_valid = 0; dout is undefined until the first write.
- All other behaviour is identical in both modes.

## Test plan
- Reset then idle, DEPTH=4: empty=1, almost_empty=1, full=0, count=0, dout_valid=0.
- Fill/drain: write 0x1,0x2,0x3,0x4 on consecutive cycles, then assert ren ×4.
  - After 4 writes: full=1, count=4, almost_full=1 (AF_LEVEL=3 reached at count 3).
  - Standard mode: dout yields 1,2,3,4 each one cycle after its ren.
  - FWFT mode: dout=1 before the first ren.
- Overflow/underflow: a 5th write while full gives overflow for one cycle; count stays 4 and the contents are unchanged. ren while empty gives underflow for one cycle.
- Full with simultaneous wen+ren: din=0xA while full; both are accepted, count stays 4, and 0xA is read out after the 3 remaining older words.
- Wrap-around: 3 writes, 3 reads, repeated 3 times with incrementing data. Every word is read out in order, empty/full are correct across pointer wrap, and count never exceeds 3.
- Mid-operation reset: assert rst_n low asynchronously (between edges) with count=2. Outputs go to reset values immediately; a subsequent write of 0x5 followed by a read returns 0x5.
